adc_scan_sequencer: RTL and testbench

- Scans the on-board 8-channel 12-bit serial ADC (LTC2308-class; CONVST/SCLK/SDI/SDO) on the 100 MHz system clock.
- Sequences conversion and serial frames over a software-selected channel set.
- Accounts for the converter's one-frame config pipeline: the result read in a frame belongs to the channel configured in the previous frame.
- Publishes each result as a one-cycle strobe and keeps a per-channel result bank for register-mapped reads.
- Sits between the bus-side register wrapper and the ADC pins (adc_convst / adc_sclk / adc_sdi / adc_sdo).

---
 rtl/adc_scan_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_adc_scan_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_sequencer.sv
// Scan sequencer for an 8-channel 12-bit serial ADC with a one-frame config pipeline.
// Each frame runs CONV -> SHIFT -> DONE; results are strobed and kept in a per-channel bank.
module adc_scan_sequencer #(
  parameter int CLK_DIV     = 2,
  parameter int CONV_CYCLES = 160
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  ch_enable,
  input  logic        auto_run,
  input  logic        start,
  output logic        busy,
  output logic        sample_valid,
  output logic [2:0]  sample_ch,
  output logic [11:0] sample_data,
  input  logic [2:0]  rd_addr,
  output logic [11:0] rd_data,
  output logic        adc_convst,
  output logic        adc_sclk,
  output logic        adc_sdi,
  input  logic        adc_sdo
);
  localparam int CW = $clog2(CONV_CYCLES + 1);
  localparam int PW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] CONV_LAST  = CW'(CONV_CYCLES - 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, CONV, SHIFT, DONE} state_t;

  state_t        state_reg;
  logic [CW-1:0] conv_cnt_reg;
  logic [PW-1:0] phase_cnt_reg;
  logic [3:0]    bit_cnt_reg;
  logic [11:0]   shift_reg;
  logic [11:0]   sdi_word_reg;
  logic [2:0]    cur_ch_reg;
  logic [2:0]    prev_ch_reg;
  logic          primed_reg;
  logic          continuous_reg;
  logic [11:0]   bank [8];
  logic [5:0]    cfg_cur;
  logic          bank_we;

  function automatic logic [5:0] cfg_word(input logic [2:0] c);
    return {1'b1, c[0], c[2], c[1], 1'b1, 1'b0};
  endfunction

  function automatic logic [2:0] lowest_ch(input logic [7:0] mask);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) if (mask[i]) r = 3'(i);
    return r;
  endfunction

  function automatic logic [2:0] highest_ch(input logic [7:0] mask);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (mask[i]) r = 3'(i);
    return r;
  endfunction

  // Nearest enabled channel above c, wrapping; falls back to c itself.
  function automatic logic [2:0] next_ch_after(input logic [2:0] c, input logic [7:0] mask);
    logic [2:0] r;
    logic [2:0] cand;
    r = c;
    for (int i = 7; i >= 1; i--) begin
      cand = c + 3'(i);
      if (mask[cand]) r = cand;
    end
    return r;
  endfunction

  assign cfg_cur = cfg_word(cur_ch_reg);
  assign bank_we = (state_reg == DONE) && primed_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      conv_cnt_reg   <= '0;
      phase_cnt_reg  <= '0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      sdi_word_reg   <= '0;
      cur_ch_reg     <= '0;
      prev_ch_reg    <= '0;
      primed_reg     <= 1'b0;
      continuous_reg <= 1'b0;
      busy           <= 1'b0;
      sample_valid   <= 1'b0;
      sample_ch      <= '0;
      sample_data    <= '0;
      adc_convst     <= 1'b0;
      adc_sclk       <= 1'b0;
      adc_sdi        <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          primed_reg <= 1'b0;
          if ((auto_run || start) && ch_enable != 8'd0) begin
            state_reg      <= CONV;
            busy           <= 1'b1;
            adc_convst     <= 1'b1;
            conv_cnt_reg   <= '0;
            cur_ch_reg     <= lowest_ch(ch_enable);
            continuous_reg <= auto_run;
          end
        end
        CONV: begin
          if (conv_cnt_reg == CONV_LAST) begin
            state_reg     <= SHIFT;
            adc_convst    <= 1'b0;
            adc_sclk      <= 1'b0;
            adc_sdi       <= cfg_cur[5];
            sdi_word_reg  <= {cfg_cur[4:0], 7'd0};
            phase_cnt_reg <= '0;
            bit_cnt_reg   <= '0;
          end else begin
            conv_cnt_reg <= conv_cnt_reg + 1'b1;
          end
        end
        SHIFT: begin
          if (phase_cnt_reg == PHASE_LAST) begin
            phase_cnt_reg <= '0;
            if (!adc_sclk) begin
              // SDO is captured on the same edge that raises SCLK
              adc_sclk  <= 1'b1;
              shift_reg <= {shift_reg[10:0], adc_sdo};
            end else begin
              adc_sclk <= 1'b0;
              if (bit_cnt_reg == 4'd11) begin
                state_reg <= DONE;
                adc_sdi   <= 1'b0;
              end else begin
                bit_cnt_reg  <= bit_cnt_reg + 4'd1;
                adc_sdi      <= sdi_word_reg[11];
                sdi_word_reg <= {sdi_word_reg[10:0], 1'b0};
              end
            end
          end else begin
            phase_cnt_reg <= phase_cnt_reg + 1'b1;
          end
        end
        DONE: begin
          // The data just shifted in belongs to the channel configured one frame earlier
          if (primed_reg) begin
            sample_valid <= 1'b1;
            sample_ch    <= prev_ch_reg;
            sample_data  <= shift_reg;
          end
          prev_ch_reg <= cur_ch_reg;
          primed_reg  <= 1'b1;
          cur_ch_reg  <= next_ch_after(cur_ch_reg, ch_enable);
          if (auto_run) continuous_reg <= 1'b1;
          if (ch_enable == 8'd0 || (!auto_run && continuous_reg) ||
              (!auto_run && primed_reg && prev_ch_reg >= highest_ch(ch_enable))) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end else begin
            state_reg    <= CONV;
            adc_convst   <= 1'b1;
            conv_cnt_reg <= '0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) bank[i] <= '0;
    end else if (bank_we) begin
      bank[prev_ch_reg] <= shift_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else       rd_data <= bank[rd_addr];
  end
endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Bench for adc_scan_sequencer: behavioural ADC with one-frame config pipeline and a result scoreboard.
module tb_adc_scan_sequencer;
  localparam int CLK_DIV     = 2;
  localparam int CONV_CYCLES = 160;
  localparam int F           = CONV_CYCLES + 24 * CLK_DIV + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  ch_enable = 8'd0;
  logic        auto_run = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  rd_addr = 3'd0;
  logic        adc_sdo = 1'b0;
  logic        busy, sample_valid, adc_convst, adc_sclk, adc_sdi;
  logic [2:0]  sample_ch;
  logic [11:0] sample_data, rd_data;

  always #5 clk = ~clk;

  adc_scan_sequencer #(.CLK_DIV(CLK_DIV), .CONV_CYCLES(CONV_CYCLES)) dut (
    .clk(clk), .reset(reset), .ch_enable(ch_enable), .auto_run(auto_run), .start(start),
    .busy(busy), .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_data(sample_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .adc_convst(adc_convst), .adc_sclk(adc_sclk),
    .adc_sdi(adc_sdi), .adc_sdo(adc_sdo)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC model state
  logic [11:0] chan_val [8];
  logic        alt_mode = 1'b0;
  logic [11:0] alt_val = 12'hFFF;
  logic [5:0]  cfg_sr = 6'd0;
  int          cfg_cnt = 0;
  logic [11:0] word = 12'd0;
  int          sdo_idx = 0;
  logic        convst_d = 1'b0, sclk_d = 1'b0, busy_d = 1'b0;
  int          busy_fall = 0;

  logic [14:0] exp_q [$];
  int          conv_t [$];
  int          strobe_t [$];
  logic [2:0]  strobe_ch [$];
  logic [11:0] strobe_dat [$];
  logic [5:0]  sdi_log [$];

  // Behavioural converter: the word read in a frame is for the config sent in the previous frame.
  always @(negedge clk) begin
    logic [2:0] c;
    if (adc_convst && !convst_d) begin
      c = {cfg_sr[3], cfg_sr[2], cfg_sr[4]};
      word = alt_mode ? alt_val : chan_val[c];
      if (busy_d) begin
        exp_q.push_back({c, word});
        if (alt_mode) alt_val = ~alt_val;
      end
      conv_t.push_back(cyc);
      sdo_idx = 0;
      adc_sdo = word[11];
      cfg_cnt = 0;
    end
    if (adc_sclk && !sclk_d && cfg_cnt < 6) begin
      cfg_sr = {cfg_sr[4:0], adc_sdi};
      cfg_cnt++;
      if (cfg_cnt == 6) sdi_log.push_back(cfg_sr);
    end
    if (!adc_sclk && sclk_d) begin
      sdo_idx++;
      adc_sdo = (sdo_idx < 12) ? word[11 - sdo_idx] : 1'b0;
    end
    if (busy_d && !busy) busy_fall = cyc;
    convst_d = adc_convst;
    sclk_d   = adc_sclk;
    busy_d   = busy;
  end

  // Scoreboard: every strobe must match the oldest outstanding conversion.
  always @(negedge clk) begin
    logic [14:0] e;
    if (sample_valid) begin
      strobe_t.push_back(cyc);
      strobe_ch.push_back(sample_ch);
      strobe_dat.push_back(sample_data);
      $display("strobe t=%0d ch=%0d data=0x%03h", cyc, sample_ch, sample_data);
      if (exp_q.size() == 0) begin
        check_val("sb_unexpected_strobe", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_val("sb_ch", 32'(sample_ch), 32'(e[14:12]));
        check_val("sb_data", 32'(sample_data), 32'(e[11:0]));
      end
    end
  end

  task automatic clear_logs();
    conv_t.delete();
    strobe_t.delete();
    strobe_ch.delete();
    strobe_dat.delete();
    sdi_log.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (busy) check_val("idle_timeout", 32'd1, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_strobes(input int cnt, input int limit);
    int n;
    n = 0;
    while (strobe_t.size() < cnt && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (strobe_t.size() < cnt) check_val("strobe_timeout", 32'(strobe_t.size()), 32'(cnt));
  endtask

  task automatic read_bank(input logic [2:0] a, input logic [11:0] exp, input string tag);
    rd_addr = a;
    repeat (2) @(negedge clk);
    check_val(tag, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int n;
    for (int i = 0; i < 8; i++) chan_val[i] = 12'h100 + 12'(i);
    chan_val[0] = 12'hA5A;
    chan_val[2] = 12'h123;

    // Reset values
    repeat (3) @(negedge clk);
    check_val("rst_pins", {29'd0, adc_convst, adc_sclk, adc_sdi}, 32'd0);
    check_val("rst_busy_valid", {30'd0, busy, sample_valid}, 32'd0);
    check_val("rst_sample", {17'd0, sample_ch, sample_data}, 32'd0);
    check_val("rst_rd_data", 32'(rd_data), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single pass over ch0 and ch2
    clear_logs();
    ch_enable = 8'h05;
    pulse_start();
    wait_idle(3000);
    check_val("t1_frames", 32'(conv_t.size()), 32'd3);
    if (conv_t.size() >= 3) begin
      check_val("t1_frame_len_a", 32'(conv_t[1] - conv_t[0]), 32'(F));
      check_val("t1_frame_len_b", 32'(conv_t[2] - conv_t[1]), 32'(F));
      check_val("t1_busy_fall", 32'(busy_fall - conv_t[0]), 32'(3 * F));
    end
    check_val("t1_strobes", 32'(strobe_t.size()), 32'd2);
    if (strobe_t.size() >= 2 && conv_t.size() >= 1) begin
      check_val("t1_strobe1_time", 32'(strobe_t[0] - conv_t[0]), 32'(2 * F));
      check_val("t1_strobe2_time", 32'(strobe_t[1] - conv_t[0]), 32'(3 * F));
    end
    check_val("t1_sdi_count", 32'(sdi_log.size()), 32'd3);
    if (sdi_log.size() >= 3) begin
      check_val("t1_sdi0", 32'(sdi_log[0]), 32'b100010);
      check_val("t1_sdi1", 32'(sdi_log[1]), 32'b100110);
      check_val("t1_sdi2", 32'(sdi_log[2]), 32'b100010);
    end
    read_bank(3'd0, 12'hA5A, "t1_bank0");
    read_bank(3'd2, 12'h123, "t1_bank2");
    read_bank(3'd5, 12'h000, "t1_bank5");

    // Empty mask: start must be ignored
    ch_enable = 8'h00;
    pulse_start();
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy || adc_convst || adc_sclk || adc_sdi) seen = 1;
    end
    check_val("t3_zero_mask_activity", 32'(seen), 32'd0);

    // Continuous scan of ch7 with alternating data
    clear_logs();
    alt_mode = 1'b1;
    alt_val = 12'hFFF;
    ch_enable = 8'h80;
    @(negedge clk);
    auto_run = 1'b1;
    wait_strobes(4, 6000);
    auto_run = 1'b0;
    wait_idle(1000);
    check_val("t4_strobes", 32'(strobe_t.size()), 32'd5);
    for (int i = 1; i < strobe_t.size(); i++)
      check_val("t4_strobe_period", 32'(strobe_t[i] - strobe_t[i-1]), 32'(F));
    if (strobe_dat.size() >= 2) begin
      check_val("t4_first_data", 32'(strobe_dat[0]), 32'hFFF);
      check_val("t4_second_data", 32'(strobe_dat[1]), 32'h000);
    end
    check_val("t4_sb_empty", 32'(exp_q.size()), 32'd0);
    alt_mode = 1'b0;

    // Mask change during auto_run
    chan_val[0] = 12'h0C0;
    chan_val[3] = 12'h333;
    chan_val[4] = 12'h444;
    clear_logs();
    ch_enable = 8'h01;
    @(negedge clk);
    auto_run = 1'b1;
    wait_strobes(2, 4000);
    ch_enable = 8'h18;
    strobe_t.delete();
    strobe_ch.delete();
    strobe_dat.delete();
    sdi_log.delete();
    wait_strobes(5, 6000);
    auto_run = 1'b0;
    wait_idle(1000);
    if (strobe_ch.size() >= 5) begin
      check_val("t5_ch0", 32'(strobe_ch[0]), 32'd0);
      check_val("t5_ch1", 32'(strobe_ch[1]), 32'd0);
      check_val("t5_ch2", 32'(strobe_ch[2]), 32'd3);
      check_val("t5_ch3", 32'(strobe_ch[3]), 32'd4);
      check_val("t5_ch4", 32'(strobe_ch[4]), 32'd3);
    end
    if (sdi_log.size() >= 4) begin
      check_val("t5_sdi0", 32'(sdi_log[0]), 32'b100010);
      check_val("t5_sdi1", 32'(sdi_log[1]), 32'b110110);
      check_val("t5_sdi2", 32'(sdi_log[2]), 32'b101010);
      check_val("t5_sdi3", 32'(sdi_log[3]), 32'b110110);
    end
    check_val("t5_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of SHIFT
    clear_logs();
    ch_enable = 8'h05;
    pulse_start();
    n = 0;
    while (conv_t.size() < 2 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_val("t6_reached_frame2", 32'(conv_t.size()), 32'd2);
    repeat (CONV_CYCLES + 20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_val("t6_pins", {29'd0, adc_convst, adc_sclk, adc_sdi}, 32'd0);
    check_val("t6_busy_valid", {30'd0, busy, sample_valid}, 32'd0);
    check_val("t6_sample", {17'd0, sample_ch, sample_data}, 32'd0);
    check_val("t6_rd_data", 32'(rd_data), 32'd0);
    reset = 1'b0;
    exp_q.delete();
    check_val("t6_no_strobe", 32'(strobe_t.size()), 32'd0);
    read_bank(3'd0, 12'h000, "t6_bank0");
    read_bank(3'd2, 12'h000, "t6_bank2");
    clear_logs();
    ch_enable = 8'h04;
    pulse_start();
    wait_idle(3000);
    check_val("t6_frames", 32'(conv_t.size()), 32'd2);
    check_val("t6_strobes", 32'(strobe_t.size()), 32'd1);
    if (strobe_t.size() >= 1 && conv_t.size() >= 1)
      check_val("t6_prime_time", 32'(strobe_t[0] - conv_t[0]), 32'(2 * F));

    // Bank read/write collision on address 2
    chan_val[2] = 12'h7E1;
    rd_addr = 3'd2;
    clear_logs();
    pulse_start();
    n = 0;
    while (!sample_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_val("t7_strobe_seen", 32'(sample_valid), 32'd1);
    check_val("t7_rd_old", 32'(rd_data), 32'h123);
    @(negedge clk);
    check_val("t7_rd_new", 32'(rd_data), 32'h7E1);
    wait_idle(1000);
    check_val("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
